// File: rtl/rotor2_return.sv
`default_nettype none
// ============================================================================
// Module      : rotor2_return
// Description : Rotor-2 return path (reflector -> keyboard). Removes the
//               rotor's rotational offset, then applies the inverse wiring.
//               Owns the rotor-2 position register (step/load) and emits a
//               turnover carry toward rotor 3. Two-stage valid/ready pipe.
// Revision    : 1.0 - initial release
// ============================================================================
module rotor2_return (
    input  logic       clk,
    input  logic       rst,
    input  logic       in_valid,
    output logic       in_ready,
    input  logic [4:0] in_letter,
    output logic       out_valid,
    input  logic       out_ready,
    output logic [4:0] out_letter,
    input  logic       step,
    input  logic       load,
    input  logic [4:0] load_pos,
    output logic [4:0] pos,
    output logic       carry
);

    localparam logic [5:0] c_alpha   = 6'd26;
    localparam logic [4:0] c_max_pos = 5'd25;
    localparam logic [4:0] c_max_let = 5'd26;

    // Inverse rotor-2 wiring, letter codes 1..26; anything else maps to 0.
    function automatic logic [4:0] f_inv(input logic [4:0] l);
        logic [4:0] r;
        case (l)
            5'd1:    r = 5'd6;
            5'd2:    r = 5'd13;
            5'd3:    r = 5'd18;
            5'd4:    r = 5'd5;
            5'd5:    r = 5'd16;
            5'd6:    r = 5'd1;
            5'd7:    r = 5'd21;
            5'd8:    r = 5'd17;
            5'd9:    r = 5'd15;
            5'd10:   r = 5'd14;
            5'd11:   r = 5'd3;
            5'd12:   r = 5'd22;
            5'd13:   r = 5'd19;
            5'd14:   r = 5'd8;
            5'd15:   r = 5'd2;
            5'd16:   r = 5'd10;
            5'd17:   r = 5'd9;
            5'd18:   r = 5'd23;
            5'd19:   r = 5'd20;
            5'd20:   r = 5'd25;
            5'd21:   r = 5'd4;
            5'd22:   r = 5'd26;
            5'd23:   r = 5'd12;
            5'd24:   r = 5'd11;
            5'd25:   r = 5'd24;
            5'd26:   r = 5'd7;
            default: r = 5'd0;
        endcase
        return r;
    endfunction

    logic [4:0] r_pos;
    logic       r_carry;
    logic       r_s1_valid;
    logic [4:0] r_s1_letter;
    logic       r_s1_err;
    logic       r_out_valid;
    logic [4:0] r_out_letter;

    logic       w_adv1;
    logic       w_adv2;
    logic [5:0] w_t;
    logic [5:0] w_d;
    logic [4:0] w_unrot;
    logic       w_err;

    // Handshake: a stage may take new data when it is empty or draining.
    always_comb begin
        w_adv2 = !r_out_valid || out_ready;
        w_adv1 = !r_s1_valid || w_adv2;
    end

    // Un-rotate: code 0 is the forward stage's wrap code for 26.
    always_comb begin
        w_t     = (in_letter == 5'd0) ? c_alpha : {1'b0, in_letter};
        w_d     = w_t + c_alpha - {1'b0, r_pos};
        w_unrot = (w_d > c_alpha) ? 5'(w_d - c_alpha) : w_d[4:0];
        w_err   = (in_letter > c_max_let);
    end

    // Position register; load beats step, out-of-range load freezes pos.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_pos   <= 5'd0;
            r_carry <= 1'b0;
        end else begin
            r_carry <= 1'b0;
            if (load) begin
                if (load_pos <= c_max_pos) begin
                    r_pos <= load_pos;
                end
            end else if (step) begin
                if (r_pos == c_max_pos) begin
                    r_pos   <= 5'd0;
                    r_carry <= 1'b1;
                end else begin
                    r_pos <= r_pos + 5'd1;
                end
            end
        end
    end

    // Stage 1: capture the un-rotated letter using the pre-edge position.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_s1_valid  <= 1'b0;
            r_s1_letter <= 5'd0;
            r_s1_err    <= 1'b0;
        end else if (w_adv1) begin
            r_s1_valid <= in_valid;
            if (in_valid) begin
                r_s1_letter <= w_unrot;
                r_s1_err    <= w_err;
            end
        end
    end

    // Stage 2: inverse wiring; an errored token leaves as letter 0.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_out_valid  <= 1'b0;
            r_out_letter <= 5'd0;
        end else if (w_adv2) begin
            r_out_valid <= r_s1_valid;
            if (r_s1_valid) begin
                r_out_letter <= r_s1_err ? 5'd0 : f_inv(r_s1_letter);
            end
        end
    end

    assign in_ready   = w_adv1;
    assign out_valid  = r_out_valid;
    assign out_letter = r_out_letter;
    assign pos        = r_pos;
    assign carry      = r_carry;

endmodule
`default_nettype wire
